// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises encoder phases A/B, decodes gray-code steps
// into a step strobe, direction bit and wrap-around position count.
module quad_decoder #(
   parameter int SIZE   = 8,
   parameter int SETTLE = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            qa,
   input  logic            qb,
   input  logic            clr,
   output logic            step,
   output logic            dir,
   output logic [SIZE-1:0] cnt,
   output logic            err
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_LAST = (SETTLE == 0) ? '0 : CW'(SETTLE - 1);

   typedef enum logic {
      SETTLING,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_UP,
      EV_DOWN,
      EV_ILLEGAL
   } event_t;

   logic            qa_s1, qb_s1;
   logic            qa_s2, qb_s2;
   logic [1:0]      prev;
   logic [1:0]      cur;
   state_t          state_q, state_d;
   logic [CW-1:0]   settle_q, settle_d;
   logic            settle_done;
   event_t          ev;
   logic            step_d;
   logic            dir_d;
   logic [SIZE-1:0] cnt_d;
   logic            err_d;

   // Position of an {a,b} pair along the up sequence 00,10,11,01.
   function automatic logic [1:0] phase_pos(input logic [1:0] ab);
      phase_pos = {ab[0], ab[1] ^ ab[0]};
   endfunction

   // Distance of one around the cycle is a step; distance two means both
   // phases toggled between samples and the direction is unknowable.
   function automatic event_t decode(input logic [1:0] p, input logic [1:0] c);
      logic [1:0] d;
      d = phase_pos(c) - phase_pos(p);
      case (d)
         2'd1:    decode = EV_UP;
         2'd3:    decode = EV_DOWN;
         2'd2:    decode = EV_ILLEGAL;
         default: decode = EV_NONE;
      endcase
   endfunction

   assign cur         = {qa_s2, qb_s2};
   assign ev          = decode(prev, cur);
   assign settle_done = (SETTLE == 0) || (settle_q == SETTLE_LAST);

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      step_d   = 1'b0;
      dir_d    = dir;
      cnt_d    = cnt;
      err_d    = err;
      case (state_q)
         SETTLING: begin
            settle_d = settle_q + CW'(1);
            if (settle_done) begin
               state_d = RUN;
            end
         end
         RUN: begin
            case (ev)
               EV_UP: begin
                  step_d = 1'b1;
                  dir_d  = 1'b1;
                  cnt_d  = cnt + SIZE'(1);
               end
               EV_DOWN: begin
                  step_d = 1'b1;
                  dir_d  = 1'b0;
                  cnt_d  = cnt - SIZE'(1);
               end
               EV_ILLEGAL: begin
                  err_d = 1'b1;
               end
               default: begin
                  step_d = 1'b0;
               end
            endcase
         end
         default: begin
            state_d = SETTLING;
         end
      endcase
      // Clear wins over any same-cycle count or error update, but the
      // step/dir report of that transition is kept.
      if (clr) begin
         cnt_d = '0;
         err_d = 1'b0;
      end
   end

   // Stage boundary: s1 -> s2 -> prev synchroniser chain, then registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         qa_s1    <= 1'b0;
         qb_s1    <= 1'b0;
         qa_s2    <= 1'b0;
         qb_s2    <= 1'b0;
         prev     <= 2'b00;
         state_q  <= SETTLING;
         settle_q <= '0;
         step     <= 1'b0;
         dir      <= 1'b0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         qa_s1    <= qa;
         qb_s1    <= qb;
         qa_s2    <= qa_s1;
         qb_s2    <= qb_s1;
         prev     <= cur;
         state_q  <= state_d;
         settle_q <= settle_d;
         step     <= step_d;
         dir      <= dir_d;
         cnt      <= cnt_d;
         err      <= err_d;
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: per-cycle vector table plus hand-written
// multi-cycle sequences for back-to-back, illegal, clear and mid-run reset cases.
module tb_quad_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       qa;
   logic       qb;
   logic       clr;
   logic       step;
   logic       dir;
   logic [7:0] cnt;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       clr;
      logic       qa;
      logic       qb;
      logic       step;
      logic       dir;
      logic [7:0] cnt;
      logic       err;
   } vec_t;

   vec_t       vq[$];
   logic [1:0] seq[7];

   quad_decoder #(.SIZE(8), .SETTLE(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .qa   (qa),
      .qb   (qb),
      .clr  (clr),
      .step (step),
      .dir  (dir),
      .cnt  (cnt),
      .err  (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic v(input logic r, input logic c, input logic a, input logic b,
                    input logic s, input logic d, input logic [7:0] n, input logic e);
      vec_t t;
      t.rst = r; t.clr = c; t.qa = a; t.qb = b;
      t.step = s; t.dir = d; t.cnt = n; t.err = e;
      vq.push_back(t);
   endtask

   // Hold {a,b} for n cycles; the decoded event lands on the third cycle.
   task automatic seg(input logic a, input logic b, input int n,
                      input logic d0, input logic [7:0] c0,
                      input logic d1, input logic [7:0] c1);
      for (int i = 0; i < n; i++) begin
         if (i < 2) v(1'b0, 1'b0, a, b, 1'b0, d0, c0, 1'b0);
         else       v(1'b0, 1'b0, a, b, (i == 2), d1, c1, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      qa  = 1'b0;
      qb  = 1'b0;

      // reset held with pins high, then released with pins still high
      for (int i = 0; i < 3; i++)  v(1, 0, 1, 1, 0, 0, 8'd0, 0);
      for (int i = 0; i < 10; i++) v(0, 0, 1, 1, 0, 0, 8'd0, 0);
      // fresh reset at 00, settle, then up count
      v(1, 0, 0, 0, 0, 0, 8'd0, 0);
      for (int i = 0; i < 4; i++)  v(0, 0, 0, 0, 0, 0, 8'd0, 0);
      seg(1, 0, 4, 0, 8'd0, 1, 8'd1);
      seg(1, 1, 4, 1, 8'd1, 1, 8'd2);
      seg(0, 1, 4, 1, 8'd2, 1, 8'd3);
      seg(0, 0, 4, 1, 8'd3, 1, 8'd4);
      seg(1, 0, 4, 1, 8'd4, 1, 8'd5);
      seg(1, 1, 3, 1, 8'd5, 1, 8'd6);
      seg(0, 1, 3, 1, 8'd6, 1, 8'd7);
      seg(0, 0, 3, 1, 8'd7, 1, 8'd8);
      // clear at 00, then down through zero
      v(0, 1, 0, 0, 0, 1, 8'd0, 0);
      seg(0, 1, 3, 1, 8'd0, 0, 8'd255);
      seg(1, 1, 3, 0, 8'd255, 0, 8'd254);
      v(0, 0, 1, 1, 0, 0, 8'd254, 0);

      for (int i = 0; i < vq.size(); i++) begin
         rst = vq[i].rst;
         clr = vq[i].clr;
         qa  = vq[i].qa;
         qb  = vq[i].qb;
         tick();
         chk($sformatf("vec%0d", i), {21'b0, step, dir, cnt, err},
             {21'b0, vq[i].step, vq[i].dir, vq[i].cnt, vq[i].err});
      end

      // reset with pins at 10 so the count phase allows cnt = 7 at 00
      rst = 1'b1; qa = 1'b1; qb = 1'b0;
      tick();
      chk("rst10", {step, dir, cnt, err}, 11'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("settle10", {step, cnt, err}, 10'd0);
      end

      // back-to-back up transitions, one per cycle
      seq = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      for (int i = 0; i < 9; i++) begin
         if (i < 7) {qa, qb} = seq[i];
         tick();
         if (i >= 2) chk($sformatf("b2b%0d", i), {step, cnt}, {1'b1, 8'(i - 1)});
      end
      tick();
      chk("b2b_end", {step, dir, cnt, err}, {1'b0, 1'b1, 8'd7, 1'b0});

      // illegal 00 -> 11
      {qa, qb} = 2'b11;
      tick();
      tick();
      chk("ill_pre", err, 0);
      tick();
      chk("ill", {step, dir, cnt, err}, {1'b0, 1'b1, 8'd7, 1'b1});
      tick();
      chk("ill_hold", {step, dir, cnt, err}, {1'b0, 1'b1, 8'd7, 1'b1});

      // err stays sticky across a valid step
      {qa, qb} = 2'b01;
      tick(); tick(); tick();
      chk("ill_sticky", {step, dir, cnt, err}, {1'b1, 1'b1, 8'd8, 1'b1});

      // clr in the cycle a valid up transition decodes
      {qa, qb} = 2'b00;
      tick(); tick();
      clr = 1'b1;
      tick();
      chk("clr_evt", {step, dir, cnt, err}, {1'b1, 1'b1, 8'd0, 1'b0});
      clr = 1'b0;
      tick();
      chk("clr_after", {step, dir, cnt, err}, {1'b0, 1'b1, 8'd0, 1'b0});

      // clr in the cycle an illegal transition decodes
      {qa, qb} = 2'b11;
      tick(); tick();
      clr = 1'b1;
      tick();
      chk("clr_ill", {step, dir, cnt, err}, {1'b0, 1'b1, 8'd0, 1'b0});
      clr = 1'b0;
      tick();
      chk("clr_ill_after", {step, dir, cnt, err}, {1'b0, 1'b1, 8'd0, 1'b0});

      // count up to 2, then reset while pins move 00 -> 10
      {qa, qb} = 2'b01;
      tick();
      {qa, qb} = 2'b00;
      tick(); tick();
      chk("pre_rst1", {step, cnt}, {1'b1, 8'd1});
      tick();
      chk("pre_rst2", {step, cnt}, {1'b1, 8'd2});
      rst = 1'b1; {qa, qb} = 2'b10;
      tick();
      chk("midrst", {step, dir, cnt, err}, 11'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("midrst_settle%0d", i), {step, cnt, err}, 10'd0);
      end
      {qa, qb} = 2'b11;
      tick(); tick(); tick();
      chk("resume", {step, dir, cnt, err}, {1'b1, 1'b1, 8'd1, 1'b0});
      tick();
      chk("resume_pulse", {step, cnt}, {1'b0, 8'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Synchronous quadrature decoder: the consumer end of the up/down counting interface. It converts a two-phase incremental-encoder signal pair (qa/qb) into a direction bit, a one-cycle step strobe and a parameterised wrap-around up/down position count. It sits between off-chip encoder pins and the control logic. It synchronises the asynchronous inputs and flags illegal double transitions.

## Interface
- SIZE, 8: width of the position count cnt.
- SETTLE, 3: clock edges after reset release during which decoding is suppressed.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- qa  input  1  encoder phase A, asynchronous to clk.
- qb  input  1  encoder phase B, asynchronous to clk.
- clr  input  1  synchronous clear of cnt and err.
- step  output  1  one-cycle pulse per valid quadrature transition.
- dir  output  1  direction of last valid transition; 1 = up, 0 = down.
- cnt  output  SIZE  position count, modulo 2^SIZE.
- err  output  1  sticky illegal-transition flag.

## Operation
- Synchroniser: two flops per input (s1, s2), then a previous-state register prev. The decode compares cur = {s2_a, s2_b} with prev = {prev_a, prev_b}.
- Up sequence, A leading B: 00→10→11→01→00.
- Down sequence: the reverse, 00→01→11→10→00.
- cur == prev: no event. step = 0; cnt, dir and err hold.
- Valid up transition: step = 1, dir = 1, cnt += 1. 2^SIZE−1 wraps to 0.
- Valid down transition: step = 1, dir = 0, cnt −= 1. 0 wraps to 2^SIZE−1.
- Illegal transition (both bits change): err = 1. step = 0; cnt and dir unchanged.
- Settle state: a counter loaded to 0 by rst counts to SETTLE.
  - Until it reaches SETTLE, prev tracks cur and no step or err is produced.
  - This prevents false events from pin levels present at reset release.
- States: SETTLING → RUN. rst returns to SETTLING from any state.
- clr (RUN only):
  - clr has priority for cnt and err: cnt = 0 and err = 0, even if a transition (valid or illegal) decodes in the same cycle.
  - step and dir still report a same-cycle valid transition.
- clr during SETTLING: cnt = 0, err = 0.

## Timing
- Reset values, after the rst edge: step = 0, dir = 0, cnt = 0, err = 0, s1 = s2 = prev = 00, settle count = 0.
- rst held for several cycles keeps every output at its reset value.
- rst asserted mid-count: cnt = 0 after the next edge. Any in-flight transition is discarded.
- Latency: an input change meeting setup before edge N is captured in s1 at N and in s2 at N+1. At edge N+2, step/dir/cnt/err register the decoded event. Outputs are visible after edge N+2, a latency of 3 edges.
- step is high for exactly one cycle per transition.
- Back-to-back transitions on consecutive cycles each produce a step pulse.
- Input transitions faster than one per clk can merge into an illegal (double) change. err flags this; it is not a lost-count guarantee.
- RUN begins at the SETTLE-th edge after rst deasserts. Events are decoded from the following edge onward.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst 3 cycles with qa = qb = 1, release, hold inputs 10 cycles. Required: step never pulses, err = 0, cnt = 0, dir = 0.
- Up count: from qa/qb = 00 after settle, drive 10, 11, 01, 00, 10, each held 4 cycles. Required:
  - 5 step pulses, dir = 1, cnt = 5.
  - Each pulse appears 3 edges after the input change.
- Down wrap (SIZE = 8): from cnt = 0 and inputs 00, drive 01, then 11. Required: cnt = 255 then 254, dir = 0, 2 pulses.
- Illegal transition: from 00 jump to 11 with cnt = 7. Required:
  - err = 1, step stays 0, cnt = 7.
  - err stays 1 across later valid steps until clr.
- clr with event: at cnt = 3, assert clr in the cycle a valid up transition decodes. Required: cnt = 0, err = 0, step = 1, dir = 1.
- Reset mid-operation: at cnt = 20 assert rst for 1 cycle while inputs move 00→10. Required: cnt = 0 next cycle, no step during SETTLING, counting resumes from 0 afterward.
